// File: rtl/dual_edge_counter_if.sv
// Output bus of dual_edge_counter: the live count driven by the counter (master)
// and read by any consumer (slave).
interface dual_edge_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data;

    modport master (output data);
    modport slave  (input  data);
endinterface

// File: rtl/dual_edge_counter.sv
// Up-counter advancing on both clock edges via two single-edge register banks.
// Define DUAL_EDGE_COUNTER_SATURATE_EN to saturate at all-ones instead of wrapping.
module dual_edge_counter #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic                clock,
    input  logic                clear,
    dual_edge_counter_if.master bus
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
`ifdef DUAL_EDGE_COUNTER_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_W  = '1;
`endif

    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Each bank builds on the value the opposite bank captured at the previous edge.
    always_comb begin
`ifdef DUAL_EDGE_COUNTER_SATURATE_EN
        rise_d = (fall_q > MAX_W - STEP_W) ? MAX_W : fall_q + STEP_W;
        fall_d = (rise_q > MAX_W - STEP_W) ? MAX_W : rise_q + STEP_W;
`else
        rise_d = fall_q + STEP_W;
        fall_d = rise_q + STEP_W;
`endif
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rise_q <= '0;
        end else begin
            rise_q <= rise_d;
        end
    end

    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            fall_q <= '0;
        end else begin
            fall_q <= fall_d;
        end
    end

    // The bank written by the most recent edge is the one matching the clock level.
    assign bus.data = clock ? rise_q : fall_q;

endmodule

// File: tb/tb_dual_edge_counter.sv
// Self-checking bench for dual_edge_counter: a STEP=1 and a STEP=3 instance share
// clock and clear and are compared against an edge-count reference model.
module tb_dual_edge_counter;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clock;
    logic clear;

    int checks     = 0;
    int errors     = 0;
    int edgesSeen  = 0;

    dual_edge_counter_if #(.WIDTH(WIDTH)) busA ();
    dual_edge_counter_if #(.WIDTH(WIDTH)) busB ();

    dual_edge_counter #(.WIDTH(WIDTH), .STEP(1)) dutA (
        .clock (clock),
        .clear (clear),
        .bus   (busA.master)
    );

    dual_edge_counter #(.WIDTH(WIDTH), .STEP(3)) dutB (
        .clock (clock),
        .clear (clear),
        .bus   (busB.master)
    );

    // Clock starts high with a period of 10.
    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    // Reference: the count is simply edges-since-release times STEP, wrapped or clamped.
    function automatic logic [WIDTH-1:0] expectedCount(input int step, input int edges);
        int total;
        total = (step % (MAXV + 1)) * edges;
`ifdef DUAL_EDGE_COUNTER_SATURATE_EN
        if (total > MAXV) total = MAXV;
        return WIDTH'(total);
`else
        return WIDTH'(total % (MAXV + 1));
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Steps over edges, sampling 1 time unit after each one.
    task automatic applyStimulus(input int nEdges, input string tag);
        for (int i = 0; i < nEdges; i++) begin
            @(clock);
            #1;
            if (!clear) edgesSeen++;
            checkOutput({tag, "_s1"}, busA.data, expectedCount(1, edgesSeen));
            checkOutput({tag, "_s3"}, busB.data, expectedCount(3, edgesSeen));
        end
    endtask

    // Called 1 unit after an edge; the pulse finishes before the next edge.
    task automatic pulseClear(input string tag);
        #($urandom_range(0, 1));
        clear = 1'b1;
        #1;
        edgesSeen = 0;
        checkOutput({tag, "_s1"}, busA.data, '0);
        checkOutput({tag, "_s3"}, busB.data, '0);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        #1;
        checkOutput("reset_s1", busA.data, '0);
        checkOutput("reset_s3", busB.data, '0);

        // Hold clear across the first three rising edges (10, 20, 30).
        applyStimulus(6, "poweron");
        clear = 1'b0;

        applyStimulus(40, "count");
`ifdef DUAL_EDGE_COUNTER_SATURATE_EN
        checkOutput("final_s1", busA.data, 4'd15);
        checkOutput("final_s3", busB.data, 4'd15);
`else
        checkOutput("final_s1", busA.data, 4'd8);
        checkOutput("final_s3", busB.data, 4'd8);
`endif

        pulseClear("clear_a");
        applyStimulus(9, "precount");
        checkOutput("nine_s1", busA.data, 4'd9);
        pulseClear("midclear");
        applyStimulus(1, "resume");
        checkOutput("resume_s1", busA.data, 4'd1);
        checkOutput("resume_s3", busB.data, 4'd3);

        repeat (10) begin
            applyStimulus($urandom_range(1, 40), "rand");
            pulseClear("rand_clear");
        end
        applyStimulus(8, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
